// File: rtl/dm_access_unit.sv
// dm_access_unit
// Data-memory access unit between the execute unit and a simple
// request/response memory bus. Each execute-unit request is checked for
// legality; a legal one becomes exactly one bus transaction (address phase,
// then response phase). The unit answers with a one-cycle done pulse, or a
// one-cycle err pulse for a misaligned access or an illegal size code.
//
// Ports
//   i_clk, i_rst_n     clock (rising edge) and async active-low reset
//   i_eu_dm_req        execute-unit request, held until done
//   i_eu_dm_wvalid     1 = store, 0 = load
//   i_eu_dm_op_data    size code: B=000 H=001 W=010 BU=100 HU=101
//   i_eu_dm_addr       byte address
//   i_eu_dm_wdata      store data (low bits of the access size are used)
//   o_eu_dm_busy       unit is not idle
//   o_eu_dm_done       completion pulse
//   o_eu_dm_err        misaligned/illegal-op pulse, replaces done
//   o_eu_dm_rdata      extended load data, held until the next done
//   o_mem_avalid       bus request valid
//   i_mem_aready       bus request accepted
//   o_mem_addr         word-aligned bus address
//   o_mem_we           bus write enable
//   o_mem_wstrb        byte-lane strobes (0000 on loads)
//   o_mem_wdata        lane-replicated store data
//   i_mem_rvalid       bus response (read data or write ack)
//   i_mem_rdata        bus read word
module dm_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_eu_dm_req,
  input  logic            i_eu_dm_wvalid,
  input  logic [2:0]      i_eu_dm_op_data,
  input  logic [XLEN-1:0] i_eu_dm_addr,
  input  logic [XLEN-1:0] i_eu_dm_wdata,
  output logic            o_eu_dm_busy,
  output logic            o_eu_dm_done,
  output logic            o_eu_dm_err,
  output logic [XLEN-1:0] o_eu_dm_rdata,
  output logic            o_mem_avalid,
  input  logic            i_mem_aready,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_we,
  output logic [3:0]      o_mem_wstrb,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic            w_legal;
  logic [3:0]      w_strb;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_loadData;

  logic [XLEN-1:0] r_addr;
  logic            r_we;
  logic [3:0]      r_wstrb;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_op;
  logic [1:0]      r_lane;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  // Legality: halfwords need an even address, words a word-aligned one;
  // unused size codes are always rejected.
  always_comb begin
    w_legal = 1'b0;
    case (i_eu_dm_op_data)
      3'b000, 3'b100: w_legal = 1'b1;
      3'b001, 3'b101: w_legal = ~i_eu_dm_addr[0];
      3'b010:         w_legal = (i_eu_dm_addr[1:0] == 2'b00);
      default:        w_legal = 1'b0;
    endcase
  end

  // Byte strobes and lane replication for stores. Replicating the data
  // into every lane means the strobes alone pick the bytes written.
  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = i_eu_dm_wdata;
    case (i_eu_dm_op_data[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << i_eu_dm_addr[1:0];
        w_wdata = {4{i_eu_dm_wdata[7:0]}};
      end
      2'b01: begin
        w_strb  = i_eu_dm_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_eu_dm_wdata[15:0]}};
      end
      default: w_strb = 4'b1111;
    endcase
    if (!i_eu_dm_wvalid) begin
      w_strb = 4'b0000;
    end
  end

  // Shifting the read word right by the byte offset puts the addressed
  // byte/halfword at bit 0; halfword offsets are always 0 or 2 here.
  assign w_shifted = i_mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_loadData = i_mem_rdata;
    case (r_op)
      3'b000:  w_loadData = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_loadData = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b001:  w_loadData = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_loadData = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: w_loadData = i_mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; rvalid is only honoured in RESP, so a response that
  // arrives with the address handshake or after an abort is dropped.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_eu_dm_req && w_legal) w_nextState = ADDR;
      ADDR:    if (i_mem_aready) w_nextState = RESP;
      RESP:    if (i_mem_rvalid) w_nextState = FIN;
      FIN:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture, err pulse and load-data capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wstrb <= 4'b0000;
      r_wdata <= '0;
      r_op    <= 3'b000;
      r_lane  <= 2'b00;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == IDLE && i_eu_dm_req) begin
        if (w_legal) begin
          r_addr  <= {i_eu_dm_addr[XLEN-1:2], 2'b00};
          r_we    <= i_eu_dm_wvalid;
          r_wstrb <= w_strb;
          r_wdata <= w_wdata;
          r_op    <= i_eu_dm_op_data;
          r_lane  <= i_eu_dm_addr[1:0];
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == RESP && i_mem_rvalid && !r_we) begin
        r_rdata <= w_loadData;
      end
    end
  end

  assign o_eu_dm_busy  = (r_state != IDLE);
  assign o_eu_dm_done  = (r_state == FIN);
  assign o_eu_dm_err   = r_err;
  assign o_eu_dm_rdata = r_rdata;
  assign o_mem_avalid  = (r_state == ADDR);
  assign o_mem_addr    = r_addr;
  assign o_mem_we      = r_we;
  assign o_mem_wstrb   = r_wstrb;
  assign o_mem_wdata   = r_wdata;

endmodule
